// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared state encoding and limits for the io_debounce input conditioner
package io_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHECK_HI  = 2'd1,
    STABLE_HI = 2'd2,
    CHECK_LO  = 2'd3
  } io_state_e;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

endpackage

// File: rtl/io_sync.sv
// rtl/io_sync.sv - N-flop synchronizer for a single asynchronous bit, resets to 0
module io_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] r_chain;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[N-2:0], d};
    end
  end

  assign q = r_chain[N-1];

endmodule

// File: rtl/io_debounce.sv
// rtl/io_debounce.sv - synchronizer, debounce FSM, edge pulses and saturating edge counter
module io_debounce
  import io_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 16,
  parameter int EVT_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 pin_in,
  input  logic [CNT_WIDTH-1:0] debounce_len,
  input  logic                 evt_clr,
  output logic                 level,
  output logic                 rise,
  output logic                 fall,
  output logic                 busy,
  output logic [EVT_WIDTH-1:0] evt_count
);

  // Out-of-range depths are clamped rather than rejected.
  localparam int SYNC_N = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN :
                          (SYNC_STAGES > SYNC_STAGES_MAX) ? SYNC_STAGES_MAX : SYNC_STAGES;
  localparam logic [CNT_WIDTH:0]   CNT_ONE = (CNT_WIDTH+1)'(1);
  localparam logic [EVT_WIDTH-1:0] EVT_ONE = EVT_WIDTH'(1);

  logic                 w_s;
  io_state_e            r_state;
  io_state_e            w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic [CNT_WIDTH:0]   w_len_eff;
  logic [CNT_WIDTH:0]   w_cnt_inc;
  logic                 w_rise_nxt;
  logic                 w_fall_nxt;
  logic                 r_level;
  logic                 r_rise;
  logic                 r_fall;
  logic                 r_busy;
  logic [EVT_WIDTH-1:0] r_evt;

  io_sync #(.N(SYNC_N)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pin_in),
    .q     (w_s)
  );

  // One extra bit keeps cnt+1 from wrapping when debounce_len is all ones.
  assign w_len_eff = (debounce_len == '0) ? CNT_ONE : {1'b0, debounce_len};
  assign w_cnt_inc = {1'b0, r_cnt} + CNT_ONE;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    if (en) begin
      case (r_state)
        STABLE_LO: if (w_s) begin
          if (w_len_eff == CNT_ONE) begin
            w_state_nxt = STABLE_HI;
            w_rise_nxt  = 1'b1;
          end else begin
            w_state_nxt = CHECK_HI;
            w_cnt_nxt   = CNT_WIDTH'(1);
          end
        end
        CHECK_HI: begin
          if (!w_s) begin
            w_state_nxt = STABLE_LO;
            w_cnt_nxt   = '0;
          end else if (w_cnt_inc >= w_len_eff) begin
            w_state_nxt = STABLE_HI;
            w_cnt_nxt   = '0;
            w_rise_nxt  = 1'b1;
          end else begin
            w_cnt_nxt   = w_cnt_inc[CNT_WIDTH-1:0];
          end
        end
        STABLE_HI: if (!w_s) begin
          if (w_len_eff == CNT_ONE) begin
            w_state_nxt = STABLE_LO;
            w_fall_nxt  = 1'b1;
          end else begin
            w_state_nxt = CHECK_LO;
            w_cnt_nxt   = CNT_WIDTH'(1);
          end
        end
        CHECK_LO: begin
          if (w_s) begin
            w_state_nxt = STABLE_HI;
            w_cnt_nxt   = '0;
          end else if (w_cnt_inc >= w_len_eff) begin
            w_state_nxt = STABLE_LO;
            w_cnt_nxt   = '0;
            w_fall_nxt  = 1'b1;
          end else begin
            w_cnt_nxt   = w_cnt_inc[CNT_WIDTH-1:0];
          end
        end
        default: w_state_nxt = STABLE_LO;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= STABLE_LO;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
      r_evt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= (w_state_nxt == STABLE_HI) || (w_state_nxt == CHECK_LO);
      r_busy  <= (w_state_nxt == CHECK_HI) || (w_state_nxt == CHECK_LO);
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      // Counted on acceptance so evt_count moves on the same edge as level.
      if (evt_clr) begin
        r_evt <= (w_rise_nxt || w_fall_nxt) ? EVT_ONE : '0;
      end else if ((w_rise_nxt || w_fall_nxt) && (r_evt != '1)) begin
        r_evt <= r_evt + EVT_ONE;
      end
    end
  end

  assign level     = r_level;
  assign rise      = r_rise;
  assign fall      = r_fall;
  assign busy      = r_busy;
  assign evt_count = r_evt;

endmodule

// File: tb/tb_io_debounce.sv
// tb/tb_io_debounce.sv - self-checking bench for io_debounce
module tb_io_debounce;

  localparam int SYNC = 2;
  localparam int CW   = 16;
  localparam int EW   = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b1;
  logic          pin_in = 1'b0;
  logic [CW-1:0] debounce_len = '0;
  logic          evt_clr = 1'b0;
  logic          level, rise, fall, busy;
  logic [EW-1:0] evt_count;

  int checks = 0;
  int failures = 0;

  // Reference: the pin (seen SYNC edges late) must differ from the accepted
  // level for L enabled cycles in a row; disabled cycles neither count nor break the run.
  int m_pipe[SYNC];
  int m_level, m_run, m_rise, m_fall, m_busy, m_evt;

  typedef struct {
    logic rst;
    logic pin;
    logic ena;
    logic clr;
    int   len;
    int   lvl;
    int   ri;
    int   fa;
    int   bsy;
    int   evt;
  } vec_t;

  vec_t tbl[16];

  always #5 clk = ~clk;

  io_debounce #(.SYNC_STAGES(SYNC), .CNT_WIDTH(CW), .EVT_WIDTH(EW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .pin_in       (pin_in),
    .debounce_len (debounce_len),
    .evt_clr      (evt_clr),
    .level        (level),
    .rise         (rise),
    .fall         (fall),
    .busy         (busy),
    .evt_count    (evt_count)
  );

  task automatic model_step();
    int s;
    int len_eff;
    if (!rst_n) begin
      for (int i = 0; i < SYNC; i++) m_pipe[i] = 0;
      m_level = 0; m_run = 0; m_rise = 0; m_fall = 0; m_busy = 0; m_evt = 0;
      return;
    end
    s = m_pipe[SYNC-1];
    len_eff = (debounce_len == 0) ? 1 : int'(debounce_len);
    m_rise = 0;
    m_fall = 0;
    if (en) begin
      if (s != m_level) begin
        m_run++;
        if (m_run >= len_eff) begin
          m_level = s;
          m_rise = s;
          m_fall = 1 - s;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end
    m_busy = (m_run != 0) ? 1 : 0;
    if (evt_clr) m_evt = (m_rise || m_fall) ? 1 : 0;
    else if ((m_rise || m_fall) && m_evt < (1 << EW) - 1) m_evt++;
    for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
    m_pipe[0] = int'(pin_in);
  endtask

  always @(posedge clk) model_step();

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input int lvl, input int ri, input int fa,
                               input int bsy, input int evt);
    check({tag, ".level"}, int'(level), lvl);
    check({tag, ".rise"}, int'(rise), ri);
    check({tag, ".fall"}, int'(fall), fa);
    check({tag, ".busy"}, int'(busy), bsy);
    check({tag, ".evt_count"}, int'(evt_count), evt);
  endtask

  task automatic check_model(input string tag);
    check_outputs(tag, m_level, m_rise, m_fall, m_busy, m_evt);
  endtask

  task automatic count_edges_to_rise(input string name, input int exp);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rise && n < 40);
    check(name, n, exp);
  endtask

  task automatic count_edges_to_fall(input string name, input int exp);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fall && n < 40);
    check(name, n, exp);
  endtask

  task automatic wait_busy(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!busy && n < 40);
    check(name, int'(busy), 1);
  endtask

  initial begin
    // rst pin en clr len | level rise fall busy evt
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4, 0, 0, 0, 0, 0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4, 0, 0, 0, 0, 0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4, 0, 0, 0, 0, 0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4, 0, 0, 0, 1, 0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4, 0, 0, 0, 1, 0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4, 0, 0, 0, 1, 0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4, 1, 1, 0, 0, 1};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4, 1, 0, 0, 0, 1};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4, 1, 0, 0, 0, 1};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4, 1, 0, 0, 0, 1};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 4, 1, 0, 0, 1, 1};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 4, 1, 0, 0, 1, 1};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 4, 1, 0, 0, 1, 1};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 4, 1, 0, 0, 0, 1};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 4, 1, 0, 0, 0, 0};
    tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 4, 1, 0, 0, 0, 0};

    // Reset release with a quiet pin.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    debounce_len = CW'(4);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_outputs("quiet", 0, 0, 0, 0, 0);
    end

    // Rise with L=4, then a 3-cycle low glitch that must be rejected.
    for (int i = 0; i < 16; i++) begin
      rst_n = tbl[i].rst;
      pin_in = tbl[i].pin;
      en = tbl[i].ena;
      evt_clr = tbl[i].clr;
      debounce_len = CW'(tbl[i].len);
      @(negedge clk);
      check_outputs($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].ri, tbl[i].fa, tbl[i].bsy, tbl[i].evt);
    end

    // debounce_len=0 acts as 1: three-edge latency both ways.
    debounce_len = '0;
    pin_in = 1'b0;
    count_edges_to_fall("len0_fall_latency", 3);
    pin_in = 1'b1;
    count_edges_to_rise("len0_rise_latency", 3);
    for (int i = 0; i < 60; i++) begin
      if (i % 5 == 0) pin_in = ~pin_in;
      @(negedge clk);
      check_model("toggle5");
    end

    // Toggle every cycle so each edge is an event; counter must saturate.
    for (int i = 0; i < 300; i++) begin
      pin_in = ~pin_in;
      @(negedge clk);
      check_model("toggle1");
    end
    check("evt_saturated", int'(evt_count), 255);
    pin_in = ~pin_in;
    evt_clr = 1'b1;
    @(negedge clk);
    check("evt_clr_with_edge", int'(evt_count), 1);
    evt_clr = 1'b0;
    repeat (6) @(negedge clk);

    // en dropped mid-check at cnt=2 with L=5.
    rst_n = 1'b0;
    pin_in = 1'b0;
    debounce_len = CW'(5);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    pin_in = 1'b1;
    wait_busy("en_busy_start");
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_outputs("en_hold", 0, 0, 0, 1, 0);
    end
    en = 1'b1;
    count_edges_to_rise("en_resume_latency", 3);
    check("en_resume_evt", int'(evt_count), 1);

    // Reset during CHECK_HI; pin still high after release.
    debounce_len = CW'(4);
    pin_in = 1'b0;
    count_edges_to_fall("pre_reset_fall", SYNC + 4);
    pin_in = 1'b1;
    wait_busy("rst_busy_start");
    rst_n = 1'b0;
    @(negedge clk);
    check_outputs("mid_reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    count_edges_to_rise("post_reset_rise", SYNC + 4);

    // Randomized traffic against the reference.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) pin_in = ~pin_in;
      en = ($urandom_range(0, 9) != 0);
      evt_clr = ($urandom_range(0, 39) == 0);
      rst_n = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 49) == 0) debounce_len = CW'($urandom_range(0, 6));
      @(negedge clk);
      check_model("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
